buffer_rec_canakari_fifo: RTL
=============================

// Module: buffer_rec_canakari_fifo
// PURPOSE
//  Parametrised receive-data FIFO between the CANakari core and SCB/OD side; replaces single-word enable register.
//  Buffers up to DEPTH words of DATA_W bits with valid/ready on both sides, first-word-fall-through output.
//  Flags writes refused while full with a sticky overflow bit, so no received word is lost silently.
// PARAMETERS
//  DATA_W   5   width of each buffered word
//  DEPTH    4   number of entries; any integer >= 2 (need not be a power of two)
// PORTS
//  clk        in   1                   single clock, rising edge
//  rst        in   1                   asynchronous reset, active-high
//  in_valid   in   1                   write request from CAN side
//  in_data    in   DATA_W              word to store
//  in_ready   out  1                   FIFO can accept a word (= !full)
//  out_valid  out  1                   out_data holds a valid word (= !empty)
//  out_data   out  DATA_W              head-of-FIFO word
//  out_ready  in   1                   consumer takes the head word
//  ovf        out  1                   sticky: write attempted while full
//  ovf_clr    in   1                   clears ovf
//  level      out  $clog2(DEPTH+1)     occupancy (only with CANAKARI_RBUF_LEVEL_EN)
// BEHAVIOUR
//  - Reset (rst=1, async): wr_ptr=rd_ptr=0, count=0, all storage=0; in_ready=1, out_valid=0, out_data=0, ovf=0, level=0.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated on same rising edge.
//  - in_ready and out_valid are registered-state decodes (count!=DEPTH, count!=0); no combinational in->out paths.
//  - Latency: word pushed at edge N appears on out_data with out_valid=1 after edge N (1 cycle) if FIFO was empty.
//  - out_data = mem[rd_ptr] (FWFT); when empty it shows the last-popped or reset value; consumers must ignore.
//  - Pointers increment by 1 and wrap from DEPTH-1 to 0 explicitly (not by bit overflow).
//  - count: +1 on push only, -1 on pop only, unchanged on push&pop or neither.
//  - Empty + in_valid + out_ready same cycle: push happens, no pop (out_valid was 0); word visible next cycle.
//  - Full + pop + in_valid same cycle: pop happens, push refused (in_ready=0); ovf set.
//  - Non-full non-empty, push&pop same cycle: both complete, count unchanged, order preserved.
//  - ovf: set on edge where in_valid & !in_ready; cleared by ovf_clr; set wins if both in same cycle.
//  - Refused word is discarded; storage and pointers unchanged.
//  - rst asserted mid-operation: all contents discarded immediately, outputs to reset values asynchronously.
//  - No state machine beyond pointers/count; states implied: EMPTY(count=0), PARTIAL, FULL(count=DEPTH).
// CONFIGURATION
//  CANAKARI_RBUF_LEVEL_EN defined: port level present, driven by count register (0..DEPTH), reset 0.
//  CANAKARI_RBUF_LEVEL_EN undefined: port level absent; count kept internally; all other behaviour identical.
// TESTING
//  T1 reset: assert rst mid-traffic -> in_ready=1, out_valid=0, out_data=0, ovf=0, level=0 without a clock edge.
//  T2 order: push 5'h01,5'h02,5'h03 (out_ready=0), then out_ready=1 -> out_data 01,02,03 on consecutive cycles, then out_valid=0.
//  T3 full/ovf: DEPTH=4, push 4 words -> in_ready=0, level=4; in_valid with 5'h1F -> ovf=1, 1F never output; ovf_clr -> ovf=0.
//  T4 full + pop + push same cycle: head popped, new word refused, count 3, ovf=1; ovf_clr & refused write same cycle -> ovf stays 1.
//  T5 wrap: DEPTH=3, stream 10 words with in_valid=out_ready=1 continuously -> all 10 out in order, count never exceeds 1.
//  T6 empty-bypass: empty, in_valid=1 data 5'h0A with out_ready=1 -> no pop that edge; next cycle out_valid=1, out_data=0A.

Source files
------------

// File: rtl/buffer_rec_canakari_fifo_if.sv
// Handshake bundle for the CANakari receive FIFO.
// The level port exists only with CANAKARI_RBUF_LEVEL_EN defined.
interface buffer_rec_canakari_fifo_if #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 4
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              ovf;
    logic              ovf_clr;
`ifdef CANAKARI_RBUF_LEVEL_EN
    logic [$clog2(DEPTH+1)-1:0] level;
`endif

    modport slave (
`ifdef CANAKARI_RBUF_LEVEL_EN
        output level,
`endif
        input  in_valid, in_data, out_ready, ovf_clr,
        output in_ready, out_valid, out_data, ovf
    );

    modport master (
`ifdef CANAKARI_RBUF_LEVEL_EN
        input  level,
`endif
        output in_valid, in_data, out_ready, ovf_clr,
        input  in_ready, out_valid, out_data, ovf
    );
endinterface

// File: rtl/buffer_rec_canakari_fifo.sv
// FWFT receive FIFO with sticky overflow flag; any DEPTH >= 2.
// Optional occupancy port: define CANAKARI_RBUF_LEVEL_EN.
module buffer_rec_canakari_fifo #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic clk,
    input  logic rst,
    buffer_rec_canakari_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              push, pop;

    assign bus.in_ready  = (count_q != CW'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.ovf       = ovf_q;
`ifdef CANAKARI_RBUF_LEVEL_EN
    assign bus.level     = count_q;
`endif

    assign push = bus.in_valid  & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // Pointers wrap explicitly so non-power-of-two depths work
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A refused write outranks a clear in the same cycle
        if (bus.in_valid && !bus.in_ready) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (push) begin
                mem_q[wr_ptr_q] <= bus.in_data;
            end
        end
    end
endmodule
